// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM back-end: command encodings and the
// read-path state enumeration.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_HOLD
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM: synchronous write, synchronous read, read-before-write.
// Addresses at or beyond MEM_DEPTH drop writes and read back as zero.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              wr_in_range;
    logic              rd_in_range;

    // Extra top bit keeps the compare exact when MEM_DEPTH == 2**ADDR_W.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI RAM back-end: decodes command words, keeps write/read pointers and
// returns read data to the SPI front-end over a valid/ready handshake.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cmd_err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr;
    logic              wr_addr_cmd;
    logic              wr_data_cmd;
    logic              rd_addr_cmd;
    logic              rd_data_cmd;
    logic              rd_accept;
    logic              rd_reject;
    logic              load_dout;
    logic              release_dout;
    logic [DATA_W-1:0] rd_data;

    // Wrap at the last implemented word, so non power-of-two depths work.
    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    assign cmd     = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];
    assign addr    = din[ADDR_W-1:0];

    assign wr_addr_cmd = rx_valid && (cmd == CMD_WR_ADDR);
    assign wr_data_cmd = rx_valid && (cmd == CMD_WR_DATA);
    assign rd_addr_cmd = rx_valid && (cmd == CMD_RD_ADDR);
    assign rd_data_cmd = rx_valid && (cmd == CMD_RD_DATA);
    assign rd_accept   = rd_data_cmd && (state == IDLE);
    assign rd_reject   = rd_data_cmd && (state != IDLE);

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_data_cmd && rst_n),
        .wr_addr (wr_ptr),
        .wr_data (payload),
        .rd_en   (rd_accept && rst_n),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_dout    = 1'b0;
        release_dout = 1'b0;
        case (state)
            IDLE: begin
                if (rd_accept) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                load_dout  = 1'b1;
                state_next = RD_HOLD;
            end
            RD_HOLD: begin
                if (tx_ready) begin
                    release_dout = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_addr_cmd) begin
                wr_ptr <= addr;
            end else if (wr_data_cmd && (AUTO_INC != 0)) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_addr_cmd) begin
                rd_ptr <= addr;
            end else if (rd_accept && (AUTO_INC != 0)) begin
                rd_ptr <= bump(rd_ptr);
            end
        end
    end

    // dout keeps its last value after the handshake; only tx_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout     <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= rd_reject;
            if (load_dout) begin
                dout     <= rd_data;
                tx_valid <= 1'b1;
            end else if (release_dout) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: three configurations driven in lockstep,
// expectations from an array/pointer model of the command set.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int N = 3;
    localparam int DEPTH_C [N] = '{256, 200, 1024};
    localparam int AW_C    [N] = '{8, 8, 10};
    localparam int DW_C    [N] = '{8, 8, 16};
    localparam int AINC_C  [N] = '{1, 1, 0};

    typedef struct {
        int inst;
        int data;
        bit chk;
        int stamp;
    } rd_exp_t;

    typedef struct {
        int inst;
        int stamp;
    } err_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic        tx_ready;
    logic [1:0]  cmd_s;
    logic [15:0] pl_s;
    logic [9:0]  din8;
    logic [17:0] din16;
    logic [7:0]  dout_def;
    logic [7:0]  dout_odd;
    logic [15:0] dout_wide;
    logic        txv_def, txv_odd, txv_wide;
    logic        err_def, err_odd, err_wide;
    logic [15:0] dout_w [N];
    logic        txv_w [N];
    logic        err_w [N];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    int       m_wp [N];
    int       m_rp [N];
    bit       m_pend [N];
    bit       m_vis [N];
    int       m_mem [N][1024];
    bit       m_known [N][1024];
    rd_exp_t  rd_q [$];
    err_exp_t err_q [$];

    bit prev_v [N];
    bit hs_prev [N];
    int held_exp [N];
    bit held_chk [N];

    assign din8  = {cmd_s, pl_s[7:0]};
    assign din16 = {cmd_s, pl_s};
    assign dout_w[0] = {8'h00, dout_def};
    assign dout_w[1] = {8'h00, dout_odd};
    assign dout_w[2] = dout_wide;
    assign txv_w[0] = txv_def;
    assign txv_w[1] = txv_odd;
    assign txv_w[2] = txv_wide;
    assign err_w[0] = err_def;
    assign err_w[1] = err_odd;
    assign err_w[2] = err_wide;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .din(din8), .rx_valid(rx_valid),
        .dout(dout_def), .tx_valid(txv_def), .tx_ready(tx_ready), .cmd_err(err_def)
    );

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .din(din8), .rx_valid(rx_valid),
        .dout(dout_odd), .tx_valid(txv_odd), .tx_ready(tx_ready), .cmd_err(err_odd)
    );

    spi_ram_ctrl #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024), .AUTO_INC(0)) dut_wide (
        .clk(clk), .rst_n(rst_n), .din(din16), .rx_valid(rx_valid),
        .dout(dout_wide), .tx_valid(txv_wide), .tx_ready(tx_ready), .cmd_err(err_wide)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(string name, int i, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
                     name, i, cyc, act, exp);
        end
    endtask

    function automatic int next_ptr(int i, int p);
        if (p == DEPTH_C[i] - 1) return 0;
        return (p + 1) % (1 << AW_C[i]);
    endfunction

    function automatic int find_rd(int i);
        for (int k = 0; k < rd_q.size(); k++) begin
            if (rd_q[k].inst == i) return k;
        end
        return -1;
    endfunction

    function automatic int find_err(int i);
        for (int k = 0; k < err_q.size(); k++) begin
            if (err_q[k].inst == i) return k;
        end
        return -1;
    endfunction

    // Predicts the effect of the coming clock edge; stamps are the cycle
    // count the monitor will see once the response is visible.
    task automatic model_step(bit rst_v, bit rx_v, logic [1:0] c, logic [15:0] p, bit rdy);
        if (!rst_v) begin
            rd_q.delete();
            err_q.delete();
            for (int i = 0; i < N; i++) begin
                m_wp[i] = 0;
                m_rp[i] = 0;
                m_pend[i] = 1'b0;
                m_vis[i] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            int      addr;
            int      data;
            bit      busy;
            rd_exp_t e;
            addr = int'(p) % (1 << AW_C[i]);
            data = int'(p) % (1 << DW_C[i]);
            busy = m_pend[i] || m_vis[i];
            if (m_pend[i]) begin
                m_pend[i] = 1'b0;
                m_vis[i] = 1'b1;
            end else if (m_vis[i] && rdy) begin
                m_vis[i] = 1'b0;
            end
            if (rx_v) begin
                case (c)
                    CMD_WR_ADDR: m_wp[i] = addr;
                    CMD_WR_DATA: begin
                        if (m_wp[i] < DEPTH_C[i]) begin
                            m_mem[i][m_wp[i]] = data;
                            m_known[i][m_wp[i]] = 1'b1;
                        end
                        if (AINC_C[i] != 0) m_wp[i] = next_ptr(i, m_wp[i]);
                    end
                    CMD_RD_ADDR: m_rp[i] = addr;
                    default: begin
                        if (busy) begin
                            err_q.push_back('{i, cyc + 1});
                        end else begin
                            e.inst = i;
                            e.stamp = cyc + 2;
                            if (m_rp[i] < DEPTH_C[i]) begin
                                e.data = m_mem[i][m_rp[i]];
                                e.chk = m_known[i][m_rp[i]];
                            end else begin
                                e.data = 0;
                                e.chk = 1'b1;
                            end
                            rd_q.push_back(e);
                            m_pend[i] = 1'b1;
                            if (AINC_C[i] != 0) m_rp[i] = next_ptr(i, m_rp[i]);
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic applyStimulus(bit rst_v, bit rx_v, logic [1:0] c, logic [15:0] p, bit rdy);
        rst_n = rst_v;
        rx_valid = rx_v;
        cmd_s = c;
        pl_s = p;
        tx_ready = rdy;
        model_step(rst_v, rx_v, c, p, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [1:0] c, logic [15:0] p, bit rdy);
        applyStimulus(1'b1, 1'b1, c, p, rdy);
    endtask

    task automatic idle(int n, bit rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, rdy);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < N; i++) begin
            checkOutput("reset_dout", i, 32'(dout_w[i]), 32'd0);
            checkOutput("reset_tx_valid", i, 32'(txv_w[i]), 32'd0);
            checkOutput("reset_cmd_err", i, 32'(err_w[i]), 32'd0);
        end
    endtask

    task automatic monitor_one(int i);
        int idx;
        if (hs_prev[i]) checkOutput("tx_valid_drop", i, 32'(txv_w[i]), 32'd0);
        if (txv_w[i] && !prev_v[i]) begin
            idx = find_rd(i);
            checkOutput("rd_expected", i, 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                checkOutput("rd_latency", i, 32'(cyc), 32'(rd_q[idx].stamp));
                if (rd_q[idx].chk) checkOutput("rd_data", i, 32'(dout_w[i]), 32'(rd_q[idx].data));
                held_exp[i] = rd_q[idx].data;
                held_chk[i] = rd_q[idx].chk;
                rd_q.delete(idx);
            end else begin
                held_chk[i] = 1'b0;
            end
        end else if (txv_w[i] && held_chk[i]) begin
            checkOutput("dout_stable", i, 32'(dout_w[i]), 32'(held_exp[i]));
        end
        idx = find_rd(i);
        if (idx >= 0 && rd_q[idx].stamp <= cyc) begin
            checkOutput("rd_missing", i, 32'(txv_w[i] && !prev_v[i]), 32'd1);
            rd_q.delete(idx);
        end
        idx = find_err(i);
        if (err_w[i]) begin
            checkOutput("cmd_err_expected", i, 32'(idx >= 0 && err_q[idx].stamp == cyc), 32'd1);
            if (idx >= 0 && err_q[idx].stamp == cyc) err_q.delete(idx);
        end else if (idx >= 0 && err_q[idx].stamp <= cyc) begin
            checkOutput("cmd_err_missing", i, 32'(err_w[i]), 32'd1);
            err_q.delete(idx);
        end
        hs_prev[i] = txv_w[i] && tx_ready;
        prev_v[i] = txv_w[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) monitor_one(i);
    end

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 7));
            1: return 16'($urandom_range(195, 205));
            2: return 16'($urandom_range(250, 255));
            default: return 16'($urandom_range(1018, 1023));
        endcase
    endfunction

    initial begin
        applyStimulus(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b11, 16'h0000, 1'b0);
        check_reset_state();

        // Basic write burst and two reads.
        send(CMD_WR_ADDR, 16'h0010, 1'b1);
        send(CMD_WR_DATA, 16'h00A5, 1'b1);
        send(CMD_WR_DATA, 16'h005A, 1'b1);
        send(CMD_RD_ADDR, 16'h0010, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(3, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(3, 1'b1);

        // Back-pressure with a rejected read inside the hold window.
        send(CMD_RD_ADDR, 16'h0010, 1'b0);
        send(CMD_RD_DATA, 16'h0000, 1'b0);
        idle(2, 1'b0);
        send(CMD_RD_DATA, 16'h0033, 1'b0);
        idle(2, 1'b0);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(2, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(3, 1'b1);

        // Pointer wrap at 0xFF and at 199.
        send(CMD_WR_ADDR, 16'h00FF, 1'b1);
        send(CMD_WR_DATA, 16'h0011, 1'b1);
        send(CMD_WR_DATA, 16'h0022, 1'b1);
        send(CMD_WR_ADDR, 16'd199, 1'b1);
        send(CMD_WR_DATA, 16'h0044, 1'b1);
        send(CMD_WR_DATA, 16'h0055, 1'b1);
        foreach (DEPTH_C[k]) begin
            send(CMD_RD_ADDR, (k == 0) ? 16'h00FF : 16'd199, 1'b1);
            send(CMD_RD_DATA, 16'h0000, 1'b1);
            idle(3, 1'b1);
            send(CMD_RD_DATA, 16'h0000, 1'b1);
            idle(3, 1'b1);
        end

        // Repeated writes/reads at one address.
        send(CMD_WR_ADDR, 16'h0004, 1'b1);
        send(CMD_WR_DATA, 16'h0001, 1'b1);
        send(CMD_WR_DATA, 16'h0002, 1'b1);
        send(CMD_WR_DATA, 16'h0003, 1'b1);
        send(CMD_RD_ADDR, 16'h0004, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send(CMD_RD_DATA, 16'h0000, 1'b1);
            idle(3, 1'b1);
        end

        // RD_DATA without rx_valid must do nothing.
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 2'b11, 16'h00FF, 1'b1);

        // Reset while the read is in flight.
        send(CMD_RD_ADDR, 16'h0000, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        check_reset_state();
        idle(2, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(3, 1'b1);

        // Top address of the wide configuration.
        send(CMD_WR_ADDR, 16'h03FF, 1'b1);
        send(CMD_WR_DATA, 16'hBEEF, 1'b1);
        send(CMD_RD_ADDR, 16'h03FF, 1'b1);
        send(CMD_RD_DATA, 16'h0000, 1'b1);
        idle(3, 1'b1);

        for (int n = 0; n < 800; n++) begin
            logic [1:0]  c;
            logic [15:0] p;
            c = 2'($urandom_range(0, 3));
            p = (c == CMD_WR_DATA || c == CMD_RD_DATA) ? 16'($urandom()) : rand_addr();
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, c, p,
                          $urandom_range(0, 1) == 1);
        end

        idle(10, 1'b1);
        checkOutput("rd_queue_drained", 0, 32'(rd_q.size()), 32'd0);
        checkOutput("err_queue_drained", 0, 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
